// File: rtl/dynamic_piso_shift_register_pkg.sv
// Shared definitions for the dynamic parallel-in/serial-out transmitter:
// default select width and the two-state FSM encoding.
package dynamic_piso_shift_register_pkg;

    localparam int SELWIDTH_DEF = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/dynamic_piso_shift_register.sv
// Variable-length PISO transmitter: accepts a word plus LEN and emits LEN+1 bits,
// highest selected bit first, so a serial-in receiver ends with data[LEN:0] == DI[LEN:0].
module dynamic_piso_shift_register
    import dynamic_piso_shift_register_pkg::*;
#(
    parameter int SELWIDTH = SELWIDTH_DEF
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     CE,
    input  logic                     LOAD,
    input  logic [SELWIDTH-1:0]      LEN,
    input  logic [2**SELWIDTH-1:0]   DI,
    output logic                     READY,
    output logic                     SO,
    output logic                     SO_VALID,
    output logic                     LAST
);

    localparam int DATAWIDTH = 2**SELWIDTH;
    localparam logic [SELWIDTH-1:0] CNT_ZERO = {SELWIDTH{1'b0}};
    localparam logic [SELWIDTH-1:0] CNT_ONE  = SELWIDTH'(1);

    state_t                 state_r;
    logic [SELWIDTH-1:0]    cnt_r;
    logic [DATAWIDTH-1:0]   word_r;
    logic                   so_r;
    logic                   so_valid_r;
    logic                   last_r;

    logic                   ready_s;
    logic                   accept_s;
    logic [SELWIDTH-1:0]    cnt_m1_s;
    logic                   next_bit_s;
    logic                   load_bit_s;

    // Handshake and bit-select mux feeding the SO register.
    always_comb begin
        ready_s    = 1'b0;
        accept_s   = 1'b0;
        cnt_m1_s   = cnt_r - CNT_ONE;
        next_bit_s = word_r[cnt_m1_s];
        load_bit_s = DI[LEN];
        if (state_r == ST_IDLE) begin
            ready_s = 1'b1;
        end else if (cnt_r == CNT_ZERO) begin
            // Final bit is on SO: a new word may follow with no gap bit.
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s = ready_s & CE & LOAD;
    end

    // Transmit FSM: state, down-counter, word register and registered outputs.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            word_r     <= {DATAWIDTH{1'b0}};
            so_r       <= 1'b0;
            so_valid_r <= 1'b0;
            last_r     <= 1'b0;
        end else if (CE) begin
            if (accept_s) begin
                state_r    <= ST_SHIFT;
                word_r     <= DI;
                cnt_r      <= LEN;
                so_r       <= load_bit_s;
                so_valid_r <= 1'b1;
                last_r     <= (LEN == CNT_ZERO);
            end else begin
                case (state_r)
                    ST_SHIFT: begin
                        if (cnt_r != CNT_ZERO) begin
                            cnt_r  <= cnt_m1_s;
                            so_r   <= next_bit_s;
                            last_r <= (cnt_r == CNT_ONE);
                        end else begin
                            state_r    <= ST_IDLE;
                            so_r       <= 1'b0;
                            so_valid_r <= 1'b0;
                            last_r     <= 1'b0;
                        end
                    end
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= CNT_ZERO;
                        so_r       <= 1'b0;
                        so_valid_r <= 1'b0;
                        last_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign READY    = ready_s;
    assign SO       = so_r;
    assign SO_VALID = so_valid_r;
    assign LAST     = last_r;

endmodule
